// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and constants for the hazard scoreboard.
//   hz_entry_t  - one tracked in-flight instruction {valid, rd, we, ld}
//   SEL_REGFILE - forward-select value meaning "read the register file"
//   HZ_BUBBLE   - empty pipeline entry
// rd is stored at HZ_RD_W bits so the struct can live in a package while the
// scoreboard stays parameterised; REG_W up to HZ_RD_W is supported and
// narrower addresses are zero-extended on entry.
package hazard_pkg;

    localparam int HZ_RD_W = 8;

    typedef struct packed {
        logic               valid;
        logic [HZ_RD_W-1:0] rd;
        logic               we;
        logic               ld;
    } hz_entry_t;

    localparam int        SEL_REGFILE = 0;
    localparam hz_entry_t HZ_BUBBLE   = '{valid: 1'b0, rd: '0, we: 1'b0, ld: 1'b0};

endpackage

// File: rtl/hazard_src_match.sv
// hazard_src_match: nearest-producer priority encoder for one source operand.
//   use_src  - the decode instruction actually reads this source
//   src      - source register address (zero-extended to HZ_RD_W)
//   ents     - tracked entries, index 1 = EX ... DEPTH = WB
//   sel      - index of the nearest matching entry, SEL_REGFILE if none
//   load_use - nearest match is a load whose data is not yet forwardable
module hazard_src_match
    import hazard_pkg::*;
#(
    parameter int DEPTH      = 3,
    parameter int LOAD_AVAIL = 2,
    parameter int SEL_W      = $clog2(DEPTH + 1)
) (
    input  logic                  use_src,
    input  logic [HZ_RD_W-1:0]    src,
    input  hz_entry_t [DEPTH:1]   ents,
    output logic [SEL_W-1:0]      sel,
    output logic                  load_use
);

    // Walk from the oldest entry to the youngest so the youngest match
    // overwrites older ones; an older matching entry never affects load_use.
    always_comb begin
        sel      = SEL_W'(SEL_REGFILE);
        load_use = 1'b0;
        for (int k = DEPTH; k >= 1; k--) begin
            if (use_src && ents[k].valid && ents[k].we && (ents[k].rd == src)) begin
                sel      = SEL_W'(k);
                load_use = ents[k].ld && (k < LOAD_AVAIL);
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: hazard detection and forwarding control beside decode.
//   clk, rst (sync, active-low)
//   id_*                    - decode-stage instruction fields
//   redirect, mem_stall     - control redirect from EX, cache stall
//   stall, flush, issue     - pipeline control for IF/ID and decode
//   rs_fwd_sel, rt_fwd_sel  - 0 = register file, k = forward from entry k
//   wb_rd, wb_write_en      - writeback port of the oldest entry
//   stall_cnt               - saturating count of load-use stall cycles
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int REG_W        = 3,
    parameter int DEPTH        = 3,
    parameter int LOAD_AVAIL   = 2,
    parameter int FLUSH_CYCLES = 3,
    parameter int CNT_W        = 16,
    parameter int SEL_W        = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_write_en,
    input  logic             id_is_load,
    input  logic             redirect,
    input  logic             mem_stall,
    output logic             stall,
    output logic             flush,
    output logic             issue,
    output logic [SEL_W-1:0] rs_fwd_sel,
    output logic [SEL_W-1:0] rt_fwd_sel,
    output logic [REG_W-1:0] wb_rd,
    output logic             wb_write_en,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int FC_W = $clog2(FLUSH_CYCLES) + 1;

    hz_entry_t [DEPTH:1] ent;
    logic [FC_W-1:0]     fcnt;
    logic [SEL_W-1:0]    rs_sel, rt_sel;
    logic                rs_lu, rt_lu, load_use;

    hazard_src_match #(.DEPTH(DEPTH), .LOAD_AVAIL(LOAD_AVAIL), .SEL_W(SEL_W)) u_rs_match (
        .use_src  (id_use_rs),
        .src      (HZ_RD_W'(id_rs)),
        .ents     (ent),
        .sel      (rs_sel),
        .load_use (rs_lu)
    );

    hazard_src_match #(.DEPTH(DEPTH), .LOAD_AVAIL(LOAD_AVAIL), .SEL_W(SEL_W)) u_rt_match (
        .use_src  (id_use_rt),
        .src      (HZ_RD_W'(id_rt)),
        .ents     (ent),
        .sel      (rt_sel),
        .load_use (rt_lu)
    );

    assign load_use = rs_lu | rt_lu;

    // A redirect squashes decode in the same cycle; the counter covers the
    // remaining FLUSH_CYCLES-1 cycles. Flush wins over a load-use stall.
    assign flush       = redirect | (fcnt != '0);
    assign stall       = mem_stall | (id_valid & load_use & ~flush);
    assign issue       = id_valid & ~stall & ~flush;
    assign rs_fwd_sel  = (stall | flush) ? SEL_W'(SEL_REGFILE) : rs_sel;
    assign rt_fwd_sel  = (stall | flush) ? SEL_W'(SEL_REGFILE) : rt_sel;
    assign wb_rd       = ent[DEPTH].rd[REG_W-1:0];
    // Gated by mem_stall so a frozen WB entry writes only on its release cycle.
    assign wb_write_en = ent[DEPTH].valid & ent[DEPTH].we & ~mem_stall;

    always_ff @(posedge clk) begin
        if (!rst) begin
            ent       <= '0;
            fcnt      <= '0;
            stall_cnt <= '0;
        end else if (!mem_stall) begin
            for (int k = DEPTH; k >= 2; k--) begin
                ent[k] <= ent[k-1];
            end
            if (issue) begin
                ent[1] <= '{valid: 1'b1, rd: HZ_RD_W'(id_rd), we: id_write_en, ld: id_is_load};
            end else begin
                ent[1] <= HZ_BUBBLE;
            end

            if (redirect) begin
                fcnt <= FC_W'(FLUSH_CYCLES - 1);
            end else if (fcnt != '0) begin
                fcnt <= fcnt - 1'b1;
            end

            if (id_valid && load_use && !flush && (stall_cnt != {CNT_W{1'b1}})) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid, id_use_rs, id_use_rt, id_write_en, id_is_load;
    logic [2:0] id_rs, id_rt, id_rd;
    logic       redirect, mem_stall;
    logic       stall, flush, issue, wb_write_en;
    logic [1:0] rs_fwd_sel, rt_fwd_sel;
    logic [2:0] wb_rd;
    logic [15:0] stall_cnt;

    // second instance with a 2-bit stall counter to see saturation
    logic       s2_stall, s2_flush, s2_issue, s2_wb_we;
    logic [1:0] s2_rs_sel, s2_rt_sel, cnt2;
    logic [2:0] s2_wb_rd;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_scoreboard dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_rd(id_rd),
        .id_write_en(id_write_en), .id_is_load(id_is_load), .redirect(redirect),
        .mem_stall(mem_stall), .stall(stall), .flush(flush), .issue(issue),
        .rs_fwd_sel(rs_fwd_sel), .rt_fwd_sel(rt_fwd_sel), .wb_rd(wb_rd),
        .wb_write_en(wb_write_en), .stall_cnt(stall_cnt)
    );

    hazard_scoreboard #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_rd(id_rd),
        .id_write_en(id_write_en), .id_is_load(id_is_load), .redirect(redirect),
        .mem_stall(mem_stall), .stall(s2_stall), .flush(s2_flush), .issue(s2_issue),
        .rs_fwd_sel(s2_rs_sel), .rt_fwd_sel(s2_rt_sel), .wb_rd(s2_wb_rd),
        .wb_write_en(s2_wb_we), .stall_cnt(cnt2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_valid = 0; id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
        id_rd = 0; id_write_en = 0; id_is_load = 0;
    endtask

    task automatic instr(input logic [2:0] rd, input logic we, input logic ld,
                         input logic [2:0] rs, input logic urs,
                         input logic [2:0] rt, input logic urt);
        id_valid = 1; id_rd = rd; id_write_en = we; id_is_load = ld;
        id_rs = rs; id_use_rs = urs; id_rt = rt; id_use_rt = urt;
    endtask

    task automatic drain();
        idle(); redirect = 0; mem_stall = 0;
        repeat (4) tick();
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (flush !== 0 || stall !== 0 || issue !== 0 || rs_fwd_sel !== 0 ||
            rt_fwd_sel !== 0 || wb_write_en !== 0 || stall_cnt !== 0) begin
            errors++;
            $display("FAIL reset_state flush=%0d stall=%0d issue=%0d rs=%0d rt=%0d wb=%0d cnt=%0d exp all 0",
                     flush, stall, issue, rs_fwd_sel, rt_fwd_sel, wb_write_en, stall_cnt);
        end
        rst = 1;
        instr(3'd1, 1, 0, 3'd2, 1, 3'd3, 1);
        #1;
        checks++;
        if (issue !== 1 || stall !== 0) begin
            errors++; $display("FAIL reset_issue issue=%0d stall=%0d exp 1/0", issue, stall);
        end
        mem_stall = 1;
        #1;
        checks++;
        if (issue !== 0 || stall !== 1) begin
            errors++; $display("FAIL reset_memstall issue=%0d stall=%0d exp 0/1", issue, stall);
        end
        mem_stall = 0;
        idle();
    endtask

    task automatic test_forwarding();
        logic [1:0] exp_sel [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
        for (int gap = 0; gap < 4; gap++) begin
            drain();
            instr(3'd1, 1, 0, 3'd0, 0, 3'd0, 0);   // ADD r1
            tick();
            idle();
            repeat (gap) tick();
            instr(3'd6, 0, 0, 3'd1, 1, 3'd4, 1);   // reads r1, r4
            #1;
            checks++;
            if (rs_fwd_sel !== exp_sel[gap] || rt_fwd_sel !== 0 || issue !== 1) begin
                errors++;
                $display("FAIL fwd_gap%0d rs_sel=%0d rt_sel=%0d issue=%0d exp %0d/0/1",
                         gap, rs_fwd_sel, rt_fwd_sel, issue, exp_sel[gap]);
            end
            if (gap == 2) begin
                checks++;
                if (wb_write_en !== 1 || wb_rd !== 3'd1) begin
                    errors++; $display("FAIL fwd_wb we=%0d rd=%0d exp 1/1", wb_write_en, wb_rd);
                end
            end
        end
        idle();
    endtask

    task automatic test_load_use();
        drain();
        instr(3'd2, 1, 1, 3'd0, 0, 3'd0, 0);       // LD r2
        tick();
        instr(3'd4, 1, 0, 3'd5, 1, 3'd2, 1);       // ADD r4 = r5 + r2
        #1;
        checks++;
        if (stall !== 1 || issue !== 0 || rt_fwd_sel !== 0 || stall_cnt !== 0) begin
            errors++;
            $display("FAIL lu_stall stall=%0d issue=%0d rt_sel=%0d cnt=%0d exp 1/0/0/0",
                     stall, issue, rt_fwd_sel, stall_cnt);
        end
        tick();
        checks++;
        if (stall !== 0 || issue !== 1 || rt_fwd_sel !== 2'd2 || rs_fwd_sel !== 0 || stall_cnt !== 16'd1) begin
            errors++;
            $display("FAIL lu_release stall=%0d issue=%0d rt_sel=%0d rs_sel=%0d cnt=%0d exp 0/1/2/0/1",
                     stall, issue, rt_fwd_sel, rs_fwd_sel, stall_cnt);
        end
        tick();
        idle();
    endtask

    task automatic test_nearest();
        drain();
        instr(3'd3, 1, 0, 3'd0, 0, 3'd0, 0);       // ADD r3
        tick();
        instr(3'd3, 1, 0, 3'd0, 0, 3'd0, 0);       // SUB r3
        tick();
        instr(3'd7, 1, 0, 3'd3, 1, 3'd0, 0);
        #1;
        checks++;
        if (rs_fwd_sel !== 2'd1) begin
            errors++; $display("FAIL nearest_alu rs_sel=%0d exp 1", rs_fwd_sel);
        end
        drain();
        instr(3'd3, 1, 0, 3'd0, 0, 3'd0, 0);       // ADD r3
        tick();
        instr(3'd3, 1, 1, 3'd0, 0, 3'd0, 0);       // LD r3
        tick();
        instr(3'd7, 1, 0, 3'd0, 0, 3'd3, 1);
        #1;
        checks++;
        if (stall !== 1 || rt_fwd_sel !== 0) begin
            errors++; $display("FAIL nearest_load stall=%0d rt_sel=%0d exp 1/0", stall, rt_fwd_sel);
        end
        tick();
        checks++;
        if (stall !== 0 || rt_fwd_sel !== 2'd2 || stall_cnt !== 16'd2) begin
            errors++;
            $display("FAIL nearest_release stall=%0d rt_sel=%0d cnt=%0d exp 0/2/2", stall, rt_fwd_sel, stall_cnt);
        end
        for (int i = 0; i < 2; i++) begin
            drain();
            instr(3'd3, 1, 1, 3'd0, 0, 3'd0, 0);
            tick();
            instr(3'd7, 1, 0, 3'd3, 1, 3'd0, 0);
            tick();
            tick();
        end
        idle();
        #1;
        checks++;
        if (stall_cnt !== 16'd4 || cnt2 !== 2'd3) begin
            errors++; $display("FAIL stall_cnt_sat cnt=%0d cnt2=%0d exp 4/3", stall_cnt, cnt2);
        end
    endtask

    task automatic test_cache_stall();
        drain();
        instr(3'd5, 1, 0, 3'd0, 0, 3'd0, 0);       // ADD r5
        tick();
        idle();
        tick();
        tick();                                    // ADD r5 now in WB
        mem_stall = 1;
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++;
            if (wb_write_en !== 0 || wb_rd !== 3'd5 || stall !== 1) begin
                errors++;
                $display("FAIL cache_hold c%0d we=%0d rd=%0d stall=%0d exp 0/5/1", c, wb_write_en, wb_rd, stall);
            end
            tick();
        end
        mem_stall = 0;
        #1;
        checks++;
        if (wb_write_en !== 1 || wb_rd !== 3'd5) begin
            errors++; $display("FAIL cache_release we=%0d rd=%0d exp 1/5", wb_write_en, wb_rd);
        end
        tick();
        checks++;
        if (wb_write_en !== 0) begin
            errors++; $display("FAIL cache_single_pulse we=%0d exp 0", wb_write_en);
        end
    endtask

    task automatic test_flush();
        logic exp_f [5];
        // single redirect
        drain();
        instr(3'd1, 1, 0, 3'd0, 0, 3'd0, 0);
        redirect = 1;
        exp_f = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++;
            if (flush !== exp_f[c] || issue !== !exp_f[c]) begin
                errors++;
                $display("FAIL flush_single c%0d flush=%0d issue=%0d exp %0d/%0d", c, flush, issue, exp_f[c], !exp_f[c]);
            end
            tick();
            redirect = 0;
        end
        // reload on flush cycle 2
        drain();
        instr(3'd1, 1, 0, 3'd0, 0, 3'd0, 0);
        redirect = 1;
        tick();
        exp_f = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        for (int c = 0; c < 4; c++) begin
            redirect = (c == 0);
            #1;
            checks++;
            if (flush !== exp_f[c]) begin
                errors++; $display("FAIL flush_reload c%0d flush=%0d exp %0d", c, flush, exp_f[c]);
            end
            tick();
        end
        redirect = 0;
        // mem_stall during flush extends it
        drain();
        instr(3'd1, 1, 0, 3'd0, 0, 3'd0, 0);
        redirect = 1;
        tick();
        redirect = 0;
        mem_stall = 1;
        tick();
        tick();
        mem_stall = 0;
        exp_f = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (flush !== exp_f[c]) begin
                errors++; $display("FAIL flush_memstall c%0d flush=%0d exp %0d", c, flush, exp_f[c]);
            end
            tick();
        end
        // flush beats load-use
        drain();
        instr(3'd2, 1, 1, 3'd0, 0, 3'd0, 0);       // LD r2
        tick();
        instr(3'd4, 1, 0, 3'd0, 0, 3'd2, 1);
        redirect = 1;
        #1;
        checks++;
        if (stall !== 0 || flush !== 1 || issue !== 0 || rt_fwd_sel !== 0) begin
            errors++;
            $display("FAIL flush_vs_lu stall=%0d flush=%0d issue=%0d rt_sel=%0d exp 0/1/0/0",
                     stall, flush, issue, rt_fwd_sel);
        end
        tick();
        redirect = 0;
        #1;
        checks++;
        if (stall_cnt !== 16'd4) begin
            errors++; $display("FAIL flush_no_count cnt=%0d exp 4", stall_cnt);
        end
        idle();
    endtask

    task automatic test_reset_mid();
        drain();
        instr(3'd1, 1, 0, 3'd0, 0, 3'd0, 0);
        tick();
        instr(3'd2, 1, 0, 3'd0, 0, 3'd0, 0);
        tick();
        redirect = 1;
        tick();
        redirect = 0;
        rst = 0;
        tick();
        rst = 1;
        instr(3'd6, 1, 0, 3'd1, 1, 3'd2, 1);
        #1;
        checks++;
        if (rs_fwd_sel !== 0 || rt_fwd_sel !== 0 || wb_write_en !== 0 || stall_cnt !== 0 ||
            cnt2 !== 0 || flush !== 0 || issue !== 1) begin
            errors++;
            $display("FAIL reset_mid rs=%0d rt=%0d wb=%0d cnt=%0d cnt2=%0d flush=%0d issue=%0d exp 0/0/0/0/0/0/1",
                     rs_fwd_sel, rt_fwd_sel, wb_write_en, stall_cnt, cnt2, flush, issue);
        end
        idle();
    endtask

    initial begin
        rst = 0; redirect = 0; mem_stall = 0;
        idle();
        tick();
        tick();
        test_reset();
        test_forwarding();
        test_load_use();
        test_nearest();
        test_cache_stall();
        test_flush();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

endmodule
